// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the buffered UART transmitter.
//   parity_t      : parity selection latched per frame
//   tx_state_t    : framing FSM states
//   DEFAULT_BAUD_DIV : default clocks per bit (0xA2D)
//   decode_parity : maps the 2-bit par_mode port onto parity_t (11 -> none)
//   parity_bit    : parity bit for a data word (zero-extended to 9 bits)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_BAUD_DIV = 2605;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic parity_t decode_parity(input logic [1:0] mode);
    parity_t p;
    case (mode)
      2'b01:   p = PAR_EVEN;
      2'b10:   p = PAR_ODD;
      default: p = PAR_NONE;
    endcase
    return p;
  endfunction

  // Zero padding of narrow words does not change the XOR reduction.
  function automatic logic parity_bit(input logic [8:0] data, input parity_t mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Small synchronous FIFO with show-ahead read: rd_data always presents the
// head entry; rd_en consumes it. Writes when full and reads when empty are
// ignored. Pointers wrap naturally because DEPTH is a power of two.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (flushes the queue)
//   wr_en     : write request, wr_data : word written
//   rd_en     : pop request,   rd_data : head word (valid when !empty)
//   full, empty, count : occupancy status
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    wr_ok_s = wr_en & (count_r != FULL_CNT);
    rd_ok_s = rd_en & (count_r != '0);
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == '0);
  assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: a word FIFO feeding a framing FSM
// (start, DATA_BITS LSB-first, optional parity, 1 or 2 stop bits).
// Parity mode and stop count are latched when a word is popped.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   tx_start  : push request, accepted when tx_rdy=1
//   tx_data   : word to push
//   par_mode  : 00 none, 01 even, 10 odd, 11 none
//   two_stop  : 1 selects two stop bits
//   tx        : serial line (idle high)
//   tx_rdy    : FIFO not full
//   tx_busy   : a frame is in progress
//   tx_done   : pulse on the last clock of the final stop bit
//   tx_ovr    : pulse when a push was dropped because the FIFO was full
//   fifo_cnt  : queued words, excluding the frame on the wire
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_start,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic [1:0]                  par_mode,
  input  logic                        two_stop,
  output logic                        tx,
  output logic                        tx_rdy,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        tx_ovr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int BD_W = $clog2(BAUD_DIV);
  localparam int BI_W = $clog2(DATA_BITS + 1);
  localparam logic [BD_W-1:0] BAUD_LAST = BD_W'(BAUD_DIV - 1);
  localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(DATA_BITS - 1);

  tx_state_t                   state_r;
  logic [BD_W-1:0]             baud_r;
  logic [BI_W-1:0]             bit_r;
  logic [DATA_BITS-1:0]        shift_r;
  parity_t                     par_r;
  logic                        par_bit_r;
  logic                        two_stop_r;
  logic                        stop_half_r;
  logic                        tx_r;
  logic                        busy_r;
  logic                        done_r;
  logic                        ovr_r;

  logic                        push_s;
  logic                        pop_s;
  logic                        baud_end_s;
  logic                        frame_end_s;
  parity_t                     par_s;
  logic [DATA_BITS-1:0]        head_s;
  logic                        full_s;
  logic                        empty_s;
  logic [$clog2(FIFO_DEPTH):0] cnt_s;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_data (tx_data),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (cnt_s)
  );

  // Push/pop handshakes and bit-timing terminal counts.
  always_comb begin
    baud_end_s  = (baud_r == BAUD_LAST);
    frame_end_s = (state_r == STOP) && baud_end_s && (!two_stop_r || stop_half_r);
    push_s      = tx_start & ~full_s;
    par_s       = decode_parity(par_mode);
    // A word is taken either from idle or on the last stop clock (back-to-back).
    if ((state_r == IDLE) || frame_end_s) begin
      pop_s = ~empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Framing FSM, baud/bit counters, latched frame config and output registers.
  // tx is registered from the current state, so the wire trails the state by
  // one clock; that gives the two-edge push-to-start latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      baud_r      <= '0;
      bit_r       <= '0;
      shift_r     <= '0;
      par_r       <= PAR_NONE;
      par_bit_r   <= 1'b0;
      two_stop_r  <= 1'b0;
      stop_half_r <= 1'b0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ovr_r  <= tx_start & full_s;

      case (state_r)
        IDLE:    tx_r <= 1'b1;
        START:   tx_r <= 1'b0;
        DATA:    tx_r <= shift_r[0];
        PARITY:  tx_r <= par_bit_r;
        STOP:    tx_r <= 1'b1;
        default: tx_r <= 1'b1;
      endcase

      case (state_r)
        IDLE: begin
          baud_r <= '0;
          if (!empty_s) begin
            shift_r     <= head_s;
            par_r       <= par_s;
            par_bit_r   <= parity_bit(9'(head_s), par_s);
            two_stop_r  <= two_stop;
            stop_half_r <= 1'b0;
            state_r     <= START;
            busy_r      <= 1'b1;
          end
        end
        START: begin
          if (baud_end_s) begin
            baud_r  <= '0;
            bit_r   <= '0;
            state_r <= DATA;
          end else begin
            baud_r <= baud_r + BD_W'(1);
          end
        end
        DATA: begin
          if (baud_end_s) begin
            baud_r  <= '0;
            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
            if (bit_r == BIT_LAST) begin
              state_r <= (par_r == PAR_NONE) ? STOP : PARITY;
            end else begin
              bit_r <= bit_r + BI_W'(1);
            end
          end else begin
            baud_r <= baud_r + BD_W'(1);
          end
        end
        PARITY: begin
          if (baud_end_s) begin
            baud_r  <= '0;
            state_r <= STOP;
          end else begin
            baud_r <= baud_r + BD_W'(1);
          end
        end
        STOP: begin
          if (baud_end_s) begin
            baud_r <= '0;
            if (two_stop_r && !stop_half_r) begin
              stop_half_r <= 1'b1;
            end else begin
              done_r <= 1'b1;
              if (!empty_s) begin
                shift_r     <= head_s;
                par_r       <= par_s;
                par_bit_r   <= parity_bit(9'(head_s), par_s);
                two_stop_r  <= two_stop;
                stop_half_r <= 1'b0;
                state_r     <= START;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end
          end else begin
            baud_r <= baud_r + BD_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_r;
  assign tx_rdy   = ~full_s;
  assign tx_busy  = busy_r;
  assign tx_done  = done_r;
  assign tx_ovr   = ovr_r;
  assign fifo_cnt = cnt_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int BD      = 8;
  localparam int TIMEOUT = 40 * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start_a = 1'b0;
  logic [7:0] tx_data_a  = 8'h00;
  logic       tx_start_b = 1'b0;
  logic [4:0] tx_data_b  = 5'h00;
  logic [1:0] par_mode   = 2'b00;
  logic       two_stop   = 1'b0;

  logic       tx_a, tx_rdy_a, tx_busy_a, tx_done_a, tx_ovr_a;
  logic [2:0] fifo_cnt_a;
  logic       tx_b, tx_rdy_b, tx_busy_b, tx_done_b, tx_ovr_b;
  logic [1:0] fifo_cnt_b;

  logic sel = 1'b0;
  logic m_tx, m_done, m_busy;
  assign m_tx   = sel ? tx_b      : tx_a;
  assign m_done = sel ? tx_done_b : tx_done_a;
  assign m_busy = sel ? tx_busy_b : tx_busy_a;

  int cyc = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int tests = 0;
  int failed = 0;

  uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .par_mode(par_mode), .two_stop(two_stop), .tx(tx_a), .tx_rdy(tx_rdy_a),
    .tx_busy(tx_busy_a), .tx_done(tx_done_a), .tx_ovr(tx_ovr_a), .fifo_cnt(fifo_cnt_a)
  );

  uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(5), .FIFO_DEPTH(2)) dut5 (
    .clk(clk), .rst(rst), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .par_mode(par_mode), .two_stop(two_stop), .tx(tx_b), .tx_rdy(tx_rdy_b),
    .tx_busy(tx_busy_b), .tx_done(tx_done_b), .tx_ovr(tx_ovr_b), .fifo_cnt(fifo_cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_done)   done_cnt <= done_cnt + 1;
    if (tx_ovr_a) ovr_cnt  <= ovr_cnt + 1;
  end

  typedef struct {
    string      name;
    logic [8:0] data;
    logic [1:0] pm;
    logic       ts;
    logic       use5;
    logic [15:0] exp_bits;
    int         exp_len;
  } vec_t;

  vec_t vecs[5];

  logic [15:0] bgot [5];
  int          bsc  [5];
  bit          bok  [5];
  logic        bdn  [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  function automatic void model_frame(input logic [8:0] d, input int nb, input logic [1:0] pm,
                                      input logic ts, output logic [15:0] bits, output int len);
    int ones;
    ones = 0;
    bits = '0;
    len  = 1;
    for (int i = 0; i < nb; i++) begin
      bits[len] = d[i];
      if (d[i]) ones++;
      len++;
    end
    if (pm == 2'b01) begin
      bits[len] = ((ones % 2) == 1);
      len++;
    end else if (pm == 2'b10) begin
      bits[len] = ((ones % 2) == 0);
      len++;
    end
    bits[len] = 1'b1;
    len++;
    if (ts) begin
      bits[len] = 1'b1;
      len++;
    end
  endfunction

  task automatic push(input logic [8:0] d, output int pcyc);
    @(negedge clk);
    if (sel) begin
      tx_start_b = 1'b1;
      tx_data_b  = d[4:0];
    end else begin
      tx_start_a = 1'b1;
      tx_data_a  = d[7:0];
    end
    @(posedge clk);
    #1;
    pcyc = cyc;
    @(negedge clk);
    tx_start_a = 1'b0;
    tx_start_b = 1'b0;
  endtask

  // Wait for a start bit, then sample each bit at its middle.
  task automatic capture(input int len, output logic [15:0] got, output int sc,
                         output bit ok, output logic dn, output logic bz);
    ok = 1'b0; got = '0; sc = 0; dn = 1'b0; bz = 1'b0;
    for (int t = 0; t < TIMEOUT; t++) begin
      @(posedge clk);
      #1;
      if (m_tx === 1'b0) begin
        ok = 1'b1;
        sc = cyc;
        break;
      end
    end
    if (ok) begin
      repeat (BD / 2) @(posedge clk);
      #1;
      got[0] = m_tx;
      bz = m_busy;
      for (int i = 1; i < len; i++) begin
        repeat (BD) @(posedge clk);
        #1;
        got[i] = m_tx;
      end
      repeat (BD - BD / 2 - 1) @(posedge clk);
      @(negedge clk);
      dn = m_done;
    end
  endtask

  task automatic run_one(input string tag, input logic [8:0] d, input logic [1:0] pm,
                         input logic ts, input logic s5, input logic [15:0] exp_bits,
                         input int exp_len);
    int pc, sc, d0;
    logic [15:0] got, mask;
    bit ok;
    logic dn, bz;
    sel = s5;
    par_mode = pm;
    two_stop = ts;
    d0 = done_cnt;
    push(d, pc);
    capture(exp_len, got, sc, ok, dn, bz);
    mask = '0;
    for (int i = 0; i < exp_len; i++) mask[i] = 1'b1;
    chk({tag, " started"}, 32'(ok), 32'd1);
    chk({tag, " bits"}, 32'(got & mask), 32'(exp_bits));
    chk({tag, " latency"}, sc - pc, 32'd2);
    chk({tag, " done on last stop clock"}, 32'(dn), 32'd1);
    chk({tag, " busy mid-frame"}, 32'(bz), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " done count"}, done_cnt - d0, 32'd1);
    chk({tag, " idle after"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    int pc, o0, d0, acc, el0, el1, s0, s1, rl, sc0;
    logic [15:0] eb0, eb1, g0, g1, rb;
    bit ok0, ok1, seen;
    logic dn0, dn1, bz;
    logic [8:0] rd;
    logic [1:0] rpm;
    logic rts;

    vecs[0] = '{"8N1 0xBE",        9'h0BE, 2'b00, 1'b0, 1'b0, 16'h037C, 10};
    vecs[1] = '{"even 0x01",       9'h001, 2'b01, 1'b0, 1'b0, 16'h0602, 11};
    vecs[2] = '{"odd 0x3C 2stop",  9'h03C, 2'b10, 1'b1, 1'b0, 16'h0E78, 12};
    vecs[3] = '{"5-bit 0x15",      9'h015, 2'b00, 1'b0, 1'b1, 16'h006A, 7};
    vecs[4] = '{"mode11 0x5A",     9'h05A, 2'b11, 1'b0, 1'b0, 16'h02B4, 10};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset tx", 32'(tx_a), 32'd1);
    chk("reset tx_rdy", 32'(tx_rdy_a), 32'd1);
    chk("reset tx_busy", 32'(tx_busy_a), 32'd0);
    chk("reset tx_done", 32'(tx_done_a), 32'd0);
    chk("reset tx_ovr", 32'(tx_ovr_a), 32'd0);
    chk("reset fifo_cnt", 32'(fifo_cnt_a), 32'd0);

    for (int v = 0; v < 5; v++) begin
      run_one(vecs[v].name, vecs[v].data, vecs[v].pm, vecs[v].ts, vecs[v].use5,
              vecs[v].exp_bits, vecs[v].exp_len);
    end

    for (int r = 0; r < 6; r++) begin
      rd  = 9'($urandom_range(0, 255));
      rpm = 2'($urandom_range(0, 3));
      rts = 1'($urandom_range(0, 1));
      model_frame(rd, 8, rpm, rts, rb, rl);
      run_one("random", rd, rpm, rts, 1'b0, rb, rl);
    end

    // Burst of FIFO_DEPTH+2 pushes in consecutive cycles.
    sel = 1'b0; par_mode = 2'b00; two_stop = 1'b0;
    o0 = ovr_cnt; d0 = done_cnt; acc = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (tx_rdy_a) acc++;
          tx_start_a = 1'b1;
          tx_data_a  = 8'((k + 1) * 17);
        end
        @(negedge clk);
        tx_start_a = 1'b0;
        chk("burst fifo_cnt full", 32'(fifo_cnt_a), 32'd4);
        chk("burst tx_rdy low", 32'(tx_rdy_a), 32'd0);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          capture(10, bgot[k], bsc[k], bok[k], bdn[k], bz);
        end
      end
    join
    chk("burst accepted", acc, 32'd5);
    chk("burst ovr pulses", ovr_cnt - o0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      model_frame(9'((k + 1) * 17), 8, 2'b00, 1'b0, eb0, el0);
      chk("burst frame started", 32'(bok[k]), 32'd1);
      chk("burst frame bits", 32'(bgot[k] & 16'h03FF), 32'(eb0));
      chk("burst frame done", 32'(bdn[k]), 32'd1);
      if (k > 0) chk("burst no gap", bsc[k] - bsc[k-1], 32'(10 * BD));
    end
    repeat (2 * BD) @(posedge clk);
    #1;
    chk("burst done count", done_cnt - d0, 32'd5);
    chk("burst idle after", 32'(tx_busy_a), 32'd0);
    chk("burst fifo empty", 32'(fifo_cnt_a), 32'd0);

    // Parity mode changed mid-frame applies only to the next frame.
    sel = 1'b0; par_mode = 2'b01; two_stop = 1'b0;
    fork
      begin
        push(9'h001, pc);
        repeat (3 * BD) @(posedge clk);
        @(negedge clk);
        par_mode = 2'b10;
        push(9'h001, pc);
      end
      begin
        capture(11, g0, s0, ok0, dn0, bz);
        capture(11, g1, s1, ok1, dn1, bz);
      end
    join
    model_frame(9'h001, 8, 2'b01, 1'b0, eb0, el0);
    model_frame(9'h001, 8, 2'b10, 1'b0, eb1, el1);
    chk("toggle frame1 bits", 32'(g0 & 16'h07FF), 32'(eb0));
    chk("toggle frame2 bits", 32'(g1 & 16'h07FF), 32'(eb1));
    chk("toggle back-to-back", s1 - s0, 32'(el0 * BD));
    par_mode = 2'b00;
    repeat (2 * BD) @(posedge clk);

    // Reset asserted during the data bits.
    sel = 1'b0;
    push(9'h000, pc);
    push(9'h033, pc);
    seen = 1'b0;
    sc0 = 0;
    for (int t = 0; t < TIMEOUT; t++) begin
      @(posedge clk);
      #1;
      if (tx_a === 1'b0) begin
        seen = 1'b1;
        sc0 = cyc;
        break;
      end
    end
    chk("rst-mid start seen", 32'(seen), 32'd1);
    repeat (3 * BD) @(posedge clk);
    #1;
    chk("rst-mid pre tx", 32'(tx_a), 32'd0);
    chk("rst-mid pre fifo_cnt", 32'(fifo_cnt_a), 32'd1);
    chk("rst-mid pre busy", 32'(tx_busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst-mid tx", 32'(tx_a), 32'd1);
    chk("rst-mid fifo_cnt", 32'(fifo_cnt_a), 32'd0);
    chk("rst-mid tx_rdy", 32'(tx_rdy_a), 32'd1);
    chk("rst-mid busy", 32'(tx_busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * BD) @(posedge clk);
    #1;
    chk("rst-mid stays idle", 32'(tx_a), 32'd1);
    model_frame(9'h05A, 8, 2'b00, 1'b0, eb0, el0);
    run_one("post-reset", 9'h05A, 2'b00, 1'b0, 1'b0, eb0, el0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
